// File: rtl/serial_add_arbiter_if.sv
// Request/result bundle between two requesters and the shared serial adder.
// The master side is the requester pair; the slave side is the arbiter.
interface serial_add_arbiter_if #(
    parameter int WIDTH = 8
);
    // reqX is a level request held high until its gntX pulse. gntX marks the
    // operand-capture edge. done pulses once per granted operation, when
    // sum/cout are valid.
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             gnt0;
    logic             gnt1;
    logic             owner;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output req0, a0, b0, req1, a1, b1,
        input  gnt0, gnt1, owner, busy, done, sum, cout
    );

    modport slave (
        input  req0, a0, b0, req1, a1, b1,
        output gnt0, gnt1, owner, busy, done, sum, cout
    );
endinterface

// File: rtl/serial_add_arbiter.sv
// Round-robin arbiter for two requesters sharing a single bit-serial adder cell.
// Operands are captured on grant and added LSB-first over WIDTH cycles.
module serial_add_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_add_arbiter_if.slave  bus,
    output logic [1:0]           state_dbg_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    // Full-adder bit cell: two half-adder stages whose carries are ORed.
    logic ha1_s, ha1_c, ha2_s, ha2_c;
    logic fa_s, fa_c;

    assign ha1_s = a_q[0] ^ b_q[0];
    assign ha1_c = a_q[0] & b_q[0];
    assign ha2_s = ha1_s ^ c_q;
    assign ha2_c = ha1_s & c_q;
    assign fa_s  = ha2_s;
    assign fa_c  = ha1_c | ha2_c;

    // Result bits enter from the MSB side so the LSB lands at bit 0 after WIDTH shifts.
    logic [WIDTH:0]   res_ext;
    logic [WIDTH-1:0] res_shift;

    assign res_ext   = {fa_s, res_q};
    assign res_shift = res_ext[WIDTH:1];

    // On a tie the requester that was not served last wins.
    logic any_req;
    logic pick1;

    assign any_req = bus.req0 | bus.req1;
    assign pick1   = bus.req1 & (~bus.req0 | ~last_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        last_d  = last_q;
        owner_d = owner_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done_d  = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = RUN;
                    a_d     = pick1 ? bus.a1 : bus.a0;
                    b_d     = pick1 ? bus.b1 : bus.b0;
                    res_d   = '0;
                    cnt_d   = '0;
                    c_d     = 1'b0;
                    owner_d = pick1;
                    last_d  = pick1;
                    gnt0_d  = ~pick1;
                    gnt1_d  = pick1;
                end
            end

            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = fa_c;
                res_d = res_shift;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    sum_d   = res_shift;
                    cout_d  = fa_c;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.gnt0    = gnt0_q;
    assign bus.gnt1    = gnt1_q;
    assign bus.owner   = owner_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.sum     = sum_q;
    assign bus.cout    = cout_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Directed bench for serial_add_arbiter: WIDTH=8 vector table, arbitration,
// operand-stability and reset-abort sequences, plus a WIDTH=1 build.
module tb_serial_add_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_add_arbiter_if #(.WIDTH(8)) bus8();
    serial_add_arbiter_if #(.WIDTH(1)) bus1();
    logic [1:0] st8, st1;

    serial_add_arbiter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8), .state_dbg_o(st8)
    );
    serial_add_arbiter #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .state_dbg_o(st1)
    );

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];
    logic [8:0] exp_front;
    logic [8:0] last_res;

    typedef struct {
        logic       which;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic       c;
    } vec_t;

    typedef struct {
        logic       a;
        logic       b;
        logic [1:0] res;
    } vec1_t;

    vec_t  vecs[6];
    vec1_t vecs1[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result scoreboard and grant/done exclusivity for the WIDTH=8 instance.
    always @(negedge clk) begin
        if (!rst) begin
            check("gnt_done_exclusive",
                  {30'd0, bus8.gnt0 & bus8.gnt1, (bus8.gnt0 | bus8.gnt1) & bus8.done}, 32'd0);
            if (bus8.done) begin
                check("done_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    exp_front = exp_q.pop_front();
                    check("result", {23'd0, bus8.cout, bus8.sum}, {23'd0, exp_front});
                end
            end
        end
    end

    task automatic drive8(input logic which, input logic req, input logic [7:0] a, input logic [7:0] b);
        if (which) begin
            bus8.req1 = req; bus8.a1 = a; bus8.b1 = b;
        end else begin
            bus8.req0 = req; bus8.a0 = a; bus8.b0 = b;
        end
    endtask

    task automatic wait_any8(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus8.gnt0 | bus8.gnt1) && n < limit);
        check("grant_seen", {31'd0, bus8.gnt0 | bus8.gnt1}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {23'd0, bus8.gnt0, bus8.gnt1, bus8.done, bus8.busy, bus8.owner,
                     bus8.cout, st8, 1'b0}, 32'd0);
        check({name, "_sum"}, {24'd0, bus8.sum}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        int k;
        drive8(v.which, 1'b1, v.a, v.b);
        wait_any8(20, n);
        check("gnt_winner", {31'd0, v.which ? bus8.gnt1 : bus8.gnt0}, 32'd1);
        check("owner", {31'd0, bus8.owner}, {31'd0, v.which});
        check("busy_at_gnt", {31'd0, bus8.busy}, 32'd1);
        drive8(v.which, 1'b0, 8'h00, 8'h00);
        exp_q.push_back({v.c, v.s});
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                check("gnt_one_cycle", {30'd0, bus8.gnt0, bus8.gnt1}, 32'd0);
                check("busy_in_run", {31'd0, bus8.busy}, 32'd1);
                check("hold_during_run", {23'd0, bus8.cout, bus8.sum}, {23'd0, last_res});
            end
        end while (!bus8.done && k < 30);
        check("latency", k, 32'd8);
        last_res = {v.c, v.s};
        @(negedge clk);
        check("done_one_cycle", {31'd0, bus8.done}, 32'd0);
        check("busy_after_done", {31'd0, bus8.busy}, 32'd0);
        check("hold_after_done", {23'd0, bus8.cout, bus8.sum}, {23'd0, last_res});
    endtask

    initial begin
        int n;
        int got;
        logic w;

        vecs[0] = '{1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0};
        vecs[1] = '{1'b1, 8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[3] = '{1'b1, 8'hFF, 8'hFF, 8'hFE, 1'b1};
        vecs[4] = '{1'b0, 8'h80, 8'h7F, 8'hFF, 1'b0};
        vecs[5] = '{1'b1, 8'h0F, 8'hF1, 8'h00, 1'b1};
        vecs1[0] = '{1'b0, 1'b0, 2'b00};
        vecs1[1] = '{1'b0, 1'b1, 2'b01};
        vecs1[2] = '{1'b1, 1'b0, 2'b01};
        vecs1[3] = '{1'b1, 1'b1, 2'b10};

        rst = 1'b1;
        bus8.req0 = 1'b0; bus8.a0 = '0; bus8.b0 = '0;
        bus8.req1 = 1'b0; bus8.a1 = '0; bus8.b1 = '0;
        bus1.req0 = 1'b0; bus1.a0 = '0; bus1.b0 = '0;
        bus1.req1 = 1'b0; bus1.a1 = '0; bus1.b1 = '0;
        last_res = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_state");
        check("reset_state_w1", {26'd0, bus1.gnt0, bus1.gnt1, bus1.done, bus1.busy,
                                 bus1.sum, bus1.cout}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Simultaneous requests after reset: 0 first, then 1, then 0 again.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_res = '0;
        drive8(1'b0, 1'b1, 8'h10, 8'h20);
        drive8(1'b1, 1'b1, 8'h80, 8'h80);
        wait_any8(20, n);
        check("tie_first_gnt0", {30'd0, bus8.gnt0, bus8.gnt1}, 32'd2);
        exp_q.push_back({1'b0, 8'h30});
        bus8.req0 = 1'b0;
        wait_any8(20, n);
        check("tie_second_gnt1", {30'd0, bus8.gnt0, bus8.gnt1}, 32'd1);
        check("grant_spacing_1", n, 32'd10);
        exp_q.push_back({1'b1, 8'h00});
        drive8(1'b0, 1'b1, 8'h01, 8'h02);
        drive8(1'b1, 1'b1, 8'h40, 8'h40);
        wait_any8(20, n);
        check("tie_third_gnt0", {30'd0, bus8.gnt0, bus8.gnt1}, 32'd2);
        check("grant_spacing_2", n, 32'd10);
        exp_q.push_back({1'b0, 8'h03});
        bus8.req0 = 1'b0;
        bus8.req1 = 1'b0;
        repeat (12) @(negedge clk);

        // Operands change after capture; req1 arrives mid-run.
        drive8(1'b0, 1'b1, 8'h12, 8'h34);
        wait_any8(20, n);
        check("stab_gnt0", {30'd0, bus8.gnt0, bus8.gnt1}, 32'd2);
        exp_q.push_back({1'b0, 8'h46});
        bus8.req0 = 1'b0;
        n = 0;
        got = 0;
        while (got == 0 && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                bus8.a0 = 8'hFF; bus8.b0 = 8'hFF;
                bus8.a1 = 8'h33; bus8.b1 = 8'h44;
            end
            if (n == 3) bus8.req1 = 1'b1;
            got = int'(bus8.gnt0 | bus8.gnt1);
        end
        check("stab_gnt1", {30'd0, bus8.gnt0, bus8.gnt1}, 32'd1);
        check("stab_spacing", n, 32'd10);
        exp_q.push_back({1'b0, 8'h77});
        bus8.req1 = 1'b0;
        repeat (11) @(negedge clk);

        // Reset four cycles into a run aborts it and clears outputs at once.
        drive8(1'b0, 1'b1, 8'h01, 8'h01);
        wait_any8(20, n);
        bus8.req0 = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive8(1'b0, 1'b1, 8'hAA, 8'h55);
        drive8(1'b1, 1'b1, 8'h01, 8'h01);
        wait_any8(20, n);
        check("post_reset_gnt0", {30'd0, bus8.gnt0, bus8.gnt1}, 32'd2);
        exp_q.push_back({1'b0, 8'hFF});
        bus8.req0 = 1'b0;
        wait_any8(20, n);
        check("post_reset_gnt1", {30'd0, bus8.gnt0, bus8.gnt1}, 32'd1);
        exp_q.push_back({1'b0, 8'h02});
        bus8.req1 = 1'b0;
        repeat (11) @(negedge clk);

        // WIDTH=1 build: done directly follows gnt.
        for (int i = 0; i < 4; i++) begin
            w = i[0];
            if (w) begin
                bus1.req1 = 1'b1; bus1.a1 = vecs1[i].a; bus1.b1 = vecs1[i].b;
            end else begin
                bus1.req0 = 1'b1; bus1.a0 = vecs1[i].a; bus1.b0 = vecs1[i].b;
            end
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(bus1.gnt0 | bus1.gnt1) && n < 10);
            check("w1_gnt", {30'd0, bus1.gnt0, bus1.gnt1}, w ? 32'd1 : 32'd2);
            check("w1_no_done_at_gnt", {31'd0, bus1.done}, 32'd0);
            bus1.req0 = 1'b0;
            bus1.req1 = 1'b0;
            @(negedge clk);
            check("w1_done", {31'd0, bus1.done}, 32'd1);
            check("w1_result", {30'd0, bus1.cout, bus1.sum}, {30'd0, vecs1[i].res});
            @(negedge clk);
        end

        check("exp_q_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
